wrr_pkt_arbiter: RTL and testbench

Weighted round-robin arbiter for REQ_NUM requesters sharing one packet-oriented downstream port. A grant is locked for a whole multi-beat packet. Each requester may keep the port for up to its programmed weight in packets before rotation. It extends the team's single-cycle round-robin arbiter with three features: weights, packet locking, and a ready handshake. It sits in front of shared buses and memory ports.

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 27 ++
 rtl/wrr_pkt_arbiter.sv | 94 +++++++++
 tb/tb_wrr_pkt_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared arbiter types and helpers: FSM state encoding and a one-hot to binary encoder.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  // Encodes a one-hot vector of up to 64 bits. Callers zero-extend the input and
  // truncate the result to their own index width.
  function automatic logic [5:0] onehot_to_idx(input logic [63:0] onehot);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < 64; i++) begin
      if (onehot[i]) idx |= 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: lowest eligible requester at or above the pointer mask, else wraps to lowest eligible.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int REQ_NUM = 8,
  localparam int IDX_W   = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] eligible,
  input  logic [REQ_NUM-1:0] ptr_mask,
  output logic [REQ_NUM-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any
);

  logic [REQ_NUM-1:0] masked;
  logic [REQ_NUM-1:0] pool;

  always_comb begin
    masked     = eligible & ptr_mask;
    pool       = (|masked) ? masked : eligible;
    // x & ~(x-1) isolates the lowest set bit
    winner     = pool & ~(pool - REQ_NUM'(1));
    winner_idx = IDX_W'(onehot_to_idx(64'(winner)));
    any        = |eligible;
  end

endmodule

// File: rtl/wrr_pkt_arbiter.sv
// Weighted round-robin packet arbiter: grants lock for whole packets, each owner keeps
// the port for up to its weight in packets, outputs decode from registered state only.
module wrr_pkt_arbiter
  import arb_pkg::*;
#(
  parameter  int REQ_NUM  = 8,
  parameter  int WEIGHT_W = 4,
  localparam int IDX_W    = $clog2(REQ_NUM)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [REQ_NUM-1:0]          reqs,
  input  logic [REQ_NUM-1:0]          req_last,
  input  logic [REQ_NUM*WEIGHT_W-1:0] weights,
  input  logic                        gnt_ready,
  output logic [REQ_NUM-1:0]          grants,
  output logic [IDX_W-1:0]            grant_idx,
  output logic                        grant_valid
);

  // Handshake: a beat transfers when the owner holds reqs high and gnt_ready is high
  // in the same BUSY cycle; req_last qualifies that beat as the packet's final one.

  arb_state_e         state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [WEIGHT_W-1:0] credit_q;
  logic               in_pkt_q;
  logic [REQ_NUM-1:0] ptr_mask_q;

  logic [REQ_NUM-1:0]  eligible;
  logic [REQ_NUM-1:0]  win_oh;
  logic [IDX_W-1:0]    win_idx;
  logic                win_any;
  logic [WEIGHT_W-1:0] win_weight;
  logic                busy;
  logic                beat;
  logic                last_beat;
  logic                release_now;
  logic                arb_en;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      eligible[i] = reqs[i] & (|weights[i*WEIGHT_W +: WEIGHT_W]);
    end
  end

  rr_pick #(.REQ_NUM(REQ_NUM)) u_pick (
    .eligible   (eligible),
    .ptr_mask   (ptr_mask_q),
    .winner     (win_oh),
    .winner_idx (win_idx),
    .any        (win_any)
  );

  always_comb begin
    win_weight  = weights[win_idx*WEIGHT_W +: WEIGHT_W];
    busy        = (state_q == ARB_BUSY);
    beat        = busy & reqs[owner_q] & gnt_ready;
    last_beat   = beat & req_last[owner_q];
    // An owner idle between packets forfeits its remaining credit
    release_now = busy & ((last_beat & (credit_q == WEIGHT_W'(1))) |
                          (~in_pkt_q & ~reqs[owner_q]));
    arb_en      = ~busy | release_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      credit_q   <= '0;
      in_pkt_q   <= 1'b0;
      ptr_mask_q <= '1;
    end else if (arb_en && win_any) begin
      state_q    <= ARB_BUSY;
      owner_q    <= win_idx;
      credit_q   <= win_weight;
      in_pkt_q   <= 1'b0;
      // Next search starts strictly above the winner; empty for the top requester
      ptr_mask_q <= ~(win_oh | (win_oh - REQ_NUM'(1)));
    end else begin
      if (release_now) state_q <= ARB_IDLE;
      if (beat) begin
        in_pkt_q <= ~req_last[owner_q];
        if (req_last[owner_q]) credit_q <= credit_q - WEIGHT_W'(1);
      end
    end
  end

  assign grants      = busy ? (REQ_NUM'(1) << owner_q) : '0;
  assign grant_idx   = busy ? owner_q : '0;
  assign grant_valid = busy;

endmodule

// File: tb/tb_wrr_pkt_arbiter.sv
// Directed bench for wrr_pkt_arbiter with hand-computed grant sequences.
module tb_wrr_pkt_arbiter;

  localparam int REQ_NUM  = 8;
  localparam int WEIGHT_W = 4;
  localparam int IDX_W    = 3;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic [REQ_NUM-1:0]          reqs = '0;
  logic [REQ_NUM-1:0]          req_last = '0;
  logic [REQ_NUM*WEIGHT_W-1:0] weights = '0;
  logic                        gnt_ready = 1'b0;
  logic [REQ_NUM-1:0]          grants;
  logic [IDX_W-1:0]            grant_idx;
  logic                        grant_valid;

  int n_checks = 0;
  int n_errors = 0;

  wrr_pkt_arbiter #(.REQ_NUM(REQ_NUM), .WEIGHT_W(WEIGHT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reqs        (reqs),
    .req_last    (req_last),
    .weights     (weights),
    .gnt_ready   (gnt_ready),
    .grants      (grants),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n     = 1'b0;
    reqs      = '0;
    req_last  = '0;
    gnt_ready = 1'b1;
    weights   = {REQ_NUM{4'h1}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int idx, input int w);
    weights[idx*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(w);
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_owner(input string tag, input int idx);
    check_eq({tag, "_grants"}, 32'(grants), 32'(1) << idx);
    check_eq({tag, "_idx"}, 32'(grant_idx), 32'(idx));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_grants"}, 32'(grants), 32'h0);
    check_eq({tag, "_idx"}, 32'(grant_idx), 32'h0);
    check_eq({tag, "_valid"}, 32'(grant_valid), 32'h0);
  endtask

  int exp_seq[8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    // Reset state and single requester regrant with no bubble
    do_reset();
    check_idle("reset");
    reqs     = 8'b0000_0001;
    req_last = 8'hFF;
    #1;
    check_eq("req_cycle_no_grant", 32'(grants), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_owner($sformatf("solo%0d", k), 0);
      check_eq($sformatf("solo%0d_valid", k), 32'(grant_valid), 32'h1);
    end

    // All requesting, weight 1: strict rotation 0..7 then wrap to 0
    do_reset();
    reqs     = 8'hFF;
    req_last = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      check_owner($sformatf("rr%0d", k), k % 8);
    end

    // Weights 3:1 gives 0,0,0,1 repeating
    do_reset();
    set_w(0, 3);
    set_w(1, 1);
    reqs     = 8'b0000_0011;
    req_last = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_owner($sformatf("wrr%0d", k), exp_seq[k]);
    end

    // 4-beat packet from 2 with two stall cycles, 5 waiting
    do_reset();
    reqs     = 8'b0010_0100;
    req_last = 8'h00;
    tick();
    check_owner("pkt_grant", 2);
    tick();
    check_owner("pkt_beat1", 2);
    tick();
    check_owner("pkt_beat2", 2);
    gnt_ready = 1'b0;
    tick();
    check_owner("pkt_stall1", 2);
    tick();
    check_owner("pkt_stall2", 2);
    gnt_ready = 1'b1;
    tick();
    check_owner("pkt_beat3", 2);
    req_last = 8'b0000_0100;
    tick();
    check_owner("pkt_after_last", 5);
    reqs     = 8'b0010_0000;
    req_last = 8'h00;

    // Owner 3 (weight 4) goes idle after one packet and forfeits its credit
    do_reset();
    set_w(3, 4);
    reqs     = 8'b0000_1000;
    req_last = 8'hFF;
    tick();
    check_owner("forfeit_grant", 3);
    tick();
    check_owner("forfeit_pkt1", 3);
    reqs = 8'b0100_0000;
    tick();
    check_owner("forfeit_to6", 6);
    reqs = 8'b1100_0001;
    tick();
    check_owner("ptr_above6", 7);
    tick();
    check_owner("ptr_wrap", 0);

    // Zero weight disables a requester
    do_reset();
    set_w(4, 0);
    reqs     = 8'b0001_0000;
    req_last = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_idle($sformatf("w0_%0d", k));
    end

    // Mid-packet request drop holds the grant, then async reset clears it
    reqs = 8'b0001_0001;
    tick();
    check_owner("viol_grant", 0);
    tick();
    check_owner("viol_beat", 0);
    reqs = 8'b0001_0000;
    tick();
    check_owner("viol_hold1", 0);
    tick();
    check_owner("viol_hold2", 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    reqs     = 8'b0001_0001;
    req_last = 8'hFF;
    tick();
    check_idle("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_owner("post_rst", 0);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
